// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled majority-vote bit recovery
module uart_rx #(
  parameter int CLK_FRQ    = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int OS_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int MID    = OVERSAMPLE / 2 - 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LO   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID);
  localparam logic [TICK_W-1:0] TICK_HI   = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic              sync1;
  logic              rx_s;
  logic              rx_prev;
  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [1:0]        samp;

  logic os_tick;
  logic start_edge;
  logic vote;
  logic at_vote;
  logic at_end;

  assign os_tick    = (div_cnt == DIV_LAST);
  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign vote       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign at_vote    = os_tick && (tick_cnt == TICK_HI);
  assign at_end     = os_tick && (tick_cnt == TICK_LAST);
  assign rx_busy    = (state == START) || (state == DATA) ||
                      (state == STOP)  || (state == BREAK);

  always_ff @(posedge clk) begin
    if (areset) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      samp      <= 2'b00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx_in;
      rx_s      <= sync1;
      rx_prev   <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Sample timing is anchored to the start edge, not to a free-running divider.
      if (start_edge) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (os_tick) begin
        div_cnt  <= '0;
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (os_tick && tick_cnt == TICK_LO)  samp[0] <= rx_s;
      if (os_tick && tick_cnt == TICK_MID) samp[1] <= rx_s;

      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (start_edge) state <= START;
        end
        START: begin
          if (at_vote && vote) state <= IDLE;
          else if (at_end)     state <= DATA;
        end
        DATA: begin
          if (at_vote) shift <= {vote, shift[7:1]};
          if (at_end) begin
            if (bit_cnt == 3'd7) state <= STOP;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // Leave at mid-stop so a following start bit is caught on its edge.
          if (at_vote) begin
            if (vote) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

  localparam int BIT_CLKS = 16;
  // start edge -> rx_valid: 2 sync clks + 9.5 bit periods + 2 ticks (1 tick = 1 clk here)
  localparam int LAT = 2 + (19 * BIT_CLKS) / 2 + 2;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FRQ   (1600000),
    .BAUD_RATE (100000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        q[$];
  ev_t        cur;
  logic [7:0] model_data = 8'h00;
  bit         chk_en = 1'b0;
  int         nerr = 0;
  int         nchk = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every pulse must match the next queued frame outcome within +/-1 tick of its due cycle.
  always @(negedge clk) begin
    if (chk_en && !areset) begin
      if (rx_valid || frame_err) begin
        chk("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
        if (rx_valid) begin
          n_valid++;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
        if (frame_err) n_err++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'({rx_valid, frame_err}), 32'd0);
        end else begin
          cur = q.pop_front();
          chk("pulse_kind", 32'({rx_valid, frame_err}), cur.err ? 32'd1 : 32'd2);
          chk("pulse_in_window", 32'((cyc >= cur.due - 1) && (cyc <= cur.due + 1)), 32'd1);
          if (!cur.err) begin
            chk("rx_data_on_valid", 32'(rx_data), 32'(cur.data));
            model_data = cur.data;
          end
        end
      end else if (q.size() > 0 && cyc > q[0].due + 1) begin
        chk("missing_pulse_due", 32'(cyc), 32'(q[0].due));
        q.delete(0);
      end
      if (!rx_valid) chk("rx_data_held", 32'(rx_data), 32'(model_data));
    end
  end

  task automatic drive(input logic v);
    @(posedge clk);
    #1;
    rx_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  // glitch_bit: frame bit index (0=start) receiving a 1-clk low at its middle sample; abort_at >= 0 stops early.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch_bit,
                            input int abort_at, input int extra_low, output int t0);
    ev_t  e;
    logic v;
    t0 = 0;
    for (int i = 0; i < 10 * BIT_CLKS; i++) begin
      int idx;
      int j;
      idx = i / BIT_CLKS;
      j   = i % BIT_CLKS;
      if (idx == 0)      v = 1'b0;
      else if (idx == 9) v = stop;
      else               v = b[idx-1];
      if (idx == glitch_bit && j == 8) v = 1'b0;
      if (i == abort_at) return;
      drive(v);
      if (i == 0) begin
        t0     = cyc;
        e.err  = !stop;
        e.data = b;
        e.due  = t0 + LAT;
        if (abort_at < 0) q.push_back(e);
      end
    end
    repeat (extra_low) drive(1'b0);
  endtask

  int t_a;
  int t_b;
  int gap;
  bit bad;
  logic [7:0] rb;

  initial begin
    areset = 1'b1;
    rx_in  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    chk_en = 1'b1;
    idle(20);

    send_frame(8'hA5, 1'b1, -1, -1, 0, t_a);
    idle(20);
    chk("a5_valid_count", 32'(n_valid), 32'd1);
    chk("a5_err_count", 32'(n_err), 32'd0);
    chk("a5_rx_data", 32'(rx_data), 32'hA5);
    chk("a5_busy_after", 32'(rx_busy), 32'd0);
    chk("a5_latency", 32'(last_valid_cyc - t_a), 32'd156);

    repeat (4) drive(1'b0);
    @(negedge clk);
    chk("false_start_busy", 32'(rx_busy), 32'd1);
    idle(20);
    chk("false_start_idle", 32'(rx_busy), 32'd0);
    chk("false_start_no_valid", 32'(n_valid), 32'd1);
    chk("false_start_no_err", 32'(n_err), 32'd0);
    chk("false_start_data", 32'(rx_data), 32'hA5);

    send_frame(8'h3C, 1'b0, -1, -1, 40, t_a);
    @(negedge clk);
    chk("break_busy", 32'(rx_busy), 32'd1);
    chk("break_err_count", 32'(n_err), 32'd1);
    chk("break_no_valid", 32'(n_valid), 32'd1);
    chk("break_data_kept", 32'(rx_data), 32'hA5);
    idle(6);
    chk("break_released", 32'(rx_busy), 32'd0);
    send_frame(8'h11, 1'b1, -1, -1, 0, t_a);
    idle(20);
    chk("after_break_data", 32'(rx_data), 32'h11);
    chk("after_break_count", 32'(n_valid), 32'd2);

    send_frame(8'h00, 1'b1, -1, -1, 0, t_a);
    send_frame(8'hFF, 1'b1, -1, -1, 0, t_b);
    idle(20);
    chk("b2b_count", 32'(n_valid), 32'd4);
    chk("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd160);
    chk("b2b_last_data", 32'(rx_data), 32'hFF);

    send_frame(8'h5A, 1'b1, -1, 5 * BIT_CLKS + 8, 0, t_a);
    areset = 1'b1;
    rx_in  = 1'b1;
    q.delete();
    model_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_rx_data", 32'(rx_data), 32'h00);
    chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
    chk("midreset_frame_err", 32'(frame_err), 32'd0);
    chk("midreset_rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    idle(20);
    chk("midreset_no_pulse", 32'(n_valid + n_err), 32'd5);
    send_frame(8'h5A, 1'b1, -1, -1, 0, t_a);
    idle(20);
    chk("midreset_fresh_data", 32'(rx_data), 32'h5A);
    chk("midreset_fresh_count", 32'(n_valid), 32'd5);

    send_frame(8'hFF, 1'b1, 2, -1, 0, t_a);
    idle(20);
    chk("glitch_vote_data", 32'(rx_data), 32'hFF);

    for (int n = 0; n < 40; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 12);
      send_frame(rb, !bad, $urandom_range(0, 12), -1, bad ? $urandom_range(0, 30) : 0, t_a);
      idle(bad ? gap + 2 : gap);
    end
    idle(30);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(rx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
